// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock into a
// 1408-bit expanded-key bus, behind a start/finish handshake.
module key_expansion (
  input  logic          clk,
  input  logic          rst,
  input  logic [127:0]  key,
  input  logic          start,
  output logic [1407:0] expanded_key,
  output logic          busy,
  output logic          finish,
  output logic          valid
);

  typedef enum logic {IDLE, EXPAND} state_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // byte b sits at bit 8*(255-b)+7, i.e. {~b, 3'b111}
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state, state_d;
  logic [3:0]   rnd;
  logic [127:0] rk [0:10];
  logic [127:0] prev, nk;
  logic [31:0]  t, n0, n1, n2, n3;
  logic         load, step, last;

  for (genvar r = 0; r < 11; r++) begin : g_out
    assign expanded_key[r*128 +: 128] = rk[r];
  end

  always_comb begin
    prev = 128'h0;
    for (int i = 0; i < 11; i++)
      if (rnd == 4'(i + 1)) prev = rk[i];
  end

  assign t  = {sb(prev[23:16]), sb(prev[15:8]),
               sb(prev[7:0]), sb(prev[31:24])}
            ^ {rcon(rnd), 24'h0};
  assign n0 = prev[127:96] ^ t;
  assign n1 = prev[95:64]  ^ n0;
  assign n2 = prev[63:32]  ^ n1;
  assign n3 = prev[31:0]   ^ n2;
  assign nk = {n0, n1, n2, n3};

  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (rnd == 4'd10) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rnd    <= 4'd0;
      busy   <= 1'b0;
      finish <= 1'b0;
      valid  <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= 128'h0;
    end else begin
      state  <= state_d;
      finish <= last;
      if (load) begin
        rk[0] <= key;
        for (int i = 1; i < 11; i++) rk[i] <= 128'h0;
        rnd   <= 4'd1;
        busy  <= 1'b1;
        valid <= 1'b0;
      end
      if (step) begin
        for (int i = 1; i < 11; i++)
          if (rnd == 4'(i)) rk[i] <= nk;
        rnd <= last ? 4'd0 : rnd + 4'd1;
        if (last) begin
          busy  <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
// Directed bench for key_expansion: FIPS-197 vectors, handshake
// timing, ignored/held start, reset abort and key changes mid-run.
module tb_key_expansion;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  key;
  logic          start;
  logic [1407:0] expanded_key;
  logic          busy, finish, valid;

  int tests = 0;
  int fails = 0;

  key_expansion dut (
    .clk(clk), .rst(rst), .key(key), .start(start),
    .expanded_key(expanded_key), .busy(busy),
    .finish(finish), .valid(valid)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] KA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KC1 = 128'h000102030405060708090a0b0c0d0e0f;

  typedef struct {
    logic [127:0] k;
    logic [127:0] s1;
    logic [127:0] s10;
    int           mode;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] slice(input int r);
    return expanded_key[r*128 +: 128];
  endfunction

  // mode 0 plain, 1 start pulse at cycle 5, 2 key scrambled each cycle
  task automatic run_exp(input vec_t v, input string tag);
    int lat;
    logic [1407:0] snap;
    lat = 0;
    @(negedge clk);
    key = v.k; start = 1'b1;
    @(posedge clk); #1;
    chk({tag, " s0_after_E0"}, slice(0), v.k);
    chk({tag, " busy_after_E0"}, 128'(busy), 128'd1);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      start = (v.mode == 1 && c == 5);
      if (v.mode == 1 && c == 5) key = KA1;
      if (v.mode == 2) key = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      if (finish && busy) chk({tag, " finish_and_busy"}, 128'd1, 128'd0);
      if (finish) begin lat = c; break; end
    end
    start = 1'b0;
    chk({tag, " latency"}, 128'(lat), 128'd10);
    chk({tag, " s0"}, slice(0), v.k);
    chk({tag, " s1"}, slice(1), v.s1);
    chk({tag, " s10"}, slice(10), v.s10);
    chk({tag, " valid"}, 128'(valid), 128'd1);
    chk({tag, " busy_done"}, 128'(busy), 128'd0);
    snap = expanded_key;
    @(posedge clk); #1;
    chk({tag, " finish_drop"}, 128'(finish), 128'd0);
    chk({tag, " valid_hold"}, 128'(valid), 128'd1);
    tests++;
    if (expanded_key !== snap) begin
      fails++;
      $display("FAIL %s idle_stable: expanded_key changed in IDLE", tag);
    end
  endtask

  initial begin
    int fcnt;
    int fpos [3];
    logic pf;

    vecs[0] = '{KA1, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0};
    vecs[1] = '{128'h0, 128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e, 0};
    vecs[2] = '{KC1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5, 1};
    vecs[3] = '{KA1, 128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 2};

    rst = 1'b1; start = 1'b0; key = KA1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (expanded_key !== '0 || busy || finish || valid) begin
      fails++;
      $display("FAIL reset_state: busy=%b finish=%b valid=%b",
               busy, finish, valid);
    end
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 4; i++) run_exp(vecs[i], $sformatf("vec%0d", i));

    // start held high: restart every 11 cycles
    @(negedge clk); key = KA1; start = 1'b1;
    @(posedge clk); #1;
    fcnt = 0; pf = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      if (pf) begin
        chk("b2b valid_drop", 128'(valid), 128'd0);
        chk("b2b busy_restart", 128'(busy), 128'd1);
        chk("b2b finish_width", 128'(finish), 128'd0);
      end
      if (finish) begin
        if (fcnt < 3) fpos[fcnt] = c;
        fcnt++;
        chk("b2b s10", slice(10), vecs[0].s10);
      end
      pf = finish;
    end
    chk("b2b finish_count", 128'(fcnt), 128'd3);
    chk("b2b pos0", 128'(fpos[0]), 128'd10);
    chk("b2b pos1", 128'(fpos[1]), 128'd21);
    chk("b2b pos2", 128'(fpos[2]), 128'd32);
    start = 1'b0;
    repeat (12) @(posedge clk);

    // reset after E4, with start held to show reset wins
    @(negedge clk); key = KA1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (expanded_key !== '0 || busy || finish || valid) begin
      fails++;
      $display("FAIL rst_abort: busy=%b finish=%b valid=%b",
               busy, finish, valid);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    run_exp(vecs[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
